// File: rtl/ctrl_pkg.sv
// Shared encodings for the RV32I main decoder: opcodes, ALU operation codes,
// ALU operand-select and writeback-source encodings.
package ctrl_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b1000;
  localparam logic [3:0] ALU_SLL  = 4'b0001;
  localparam logic [3:0] ALU_SLT  = 4'b0010;
  localparam logic [3:0] ALU_SLTU = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SRL  = 4'b0101;
  localparam logic [3:0] ALU_SRA  = 4'b1101;
  localparam logic [3:0] ALU_OR   = 4'b0110;
  localparam logic [3:0] ALU_AND  = 4'b0111;

  localparam logic [1:0] ASRC_RS1_RS2 = 2'b00;
  localparam logic [1:0] ASRC_RS1_IMM = 2'b01;
  localparam logic [1:0] ASRC_PC_IMM  = 2'b10;

  localparam logic [1:0] WB_ALU  = 2'b00;
  localparam logic [1:0] WB_MEM  = 2'b01;
  localparam logic [1:0] WB_PC4  = 2'b10;
  localparam logic [1:0] WB_IMM  = 2'b11;

endpackage

// File: rtl/alu_op_dec.sv
// Funct-level decode: derives the 4-bit ALU operation from opcode/funct3/funct7
// and flags funct combinations that the datapath does not support.
module alu_op_dec
  import ctrl_pkg::*;
(
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  output logic [3:0] alu_op,
  output logic       funct_illegal
);

  logic alt_capable;

  // Only ADD/SUB and SRL/SRA have an alternate (funct7[5]) form.
  assign alt_capable = (funct3 == 3'b000) || (funct3 == 3'b101);

  always_comb begin
    alu_op        = ALU_ADD;
    funct_illegal = 1'b0;
    case (opcode)
      OP_R: begin
        alu_op = {funct7[5] & alt_capable, funct3};
        if (!((funct7 == F7_BASE) || ((funct7 == F7_ALT) && alt_capable)))
          funct_illegal = 1'b1;
      end
      OP_IMM: begin
        alu_op = {(funct3 == 3'b101) & funct7[5], funct3};
      end
      OP_BRANCH: begin
        case (funct3[2:1])
          2'b00:   alu_op = ALU_SUB;
          2'b10:   alu_op = ALU_SLT;
          2'b11:   alu_op = ALU_SLTU;
          default: funct_illegal = 1'b1;
        endcase
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// RV32I main decoder with combinational control outputs and clocked illegal-event tracking.
// Build option: define CTRL_ILLEGAL_CNT_EN to build the saturating illegal_cnt counter.
module control_unit
  import ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  output logic       reg_write,
  output logic       mem_read,
  output logic       mem_write,
  output logic       branch,
  output logic       jump,
  output logic [1:0] alu_src,
  output logic [3:0] alu_op,
  output logic [1:0] reg_write_src,
  output logic       illegal_inst,
  output logic       illegal_sticky,
  output logic [7:0] illegal_cnt
);

  logic [3:0] dec_alu_op;
  logic       funct_illegal;
  logic       op_illegal;

  alu_op_dec u_alu_op_dec (
    .opcode        (opcode),
    .funct3        (funct3),
    .funct7        (funct7),
    .alu_op        (dec_alu_op),
    .funct_illegal (funct_illegal)
  );

  always_comb begin
    reg_write     = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    branch        = 1'b0;
    jump          = 1'b0;
    alu_src       = ASRC_RS1_RS2;
    alu_op        = dec_alu_op;
    reg_write_src = WB_ALU;
    op_illegal    = 1'b0;
    case (opcode)
      OP_R:      reg_write = 1'b1;
      OP_IMM:    begin reg_write = 1'b1; alu_src = ASRC_RS1_IMM; end
      OP_LOAD:   begin
        reg_write     = 1'b1;
        mem_read      = 1'b1;
        alu_src       = ASRC_RS1_IMM;
        reg_write_src = WB_MEM;
      end
      OP_STORE:  begin mem_write = 1'b1; alu_src = ASRC_RS1_IMM; end
      OP_BRANCH: branch = 1'b1;
      OP_JAL:    begin reg_write = 1'b1; jump = 1'b1; reg_write_src = WB_PC4; end
      OP_JALR:   begin
        reg_write     = 1'b1;
        jump          = 1'b1;
        alu_src       = ASRC_RS1_IMM;
        reg_write_src = WB_PC4;
      end
      OP_LUI:    begin reg_write = 1'b1; reg_write_src = WB_IMM; end
      OP_AUIPC:  begin reg_write = 1'b1; alu_src = ASRC_PC_IMM; end
      OP_FENCE, OP_SYSTEM: ;
      default:   op_illegal = 1'b1;
    endcase

    illegal_inst = op_illegal | funct_illegal;
    // An unsupported encoding must never commit state, so every control drops to 0.
    if (illegal_inst) begin
      reg_write     = 1'b0;
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      branch        = 1'b0;
      jump          = 1'b0;
      alu_src       = ASRC_RS1_RS2;
      alu_op        = ALU_ADD;
      reg_write_src = WB_ALU;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      illegal_sticky <= 1'b0;
    else if (illegal_inst)
      illegal_sticky <= 1'b1;
  end

`ifdef CTRL_ILLEGAL_CNT_EN
  logic [7:0] cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      cnt_q <= 8'd0;
    else if (illegal_inst && (cnt_q != 8'hFF))
      cnt_q <= cnt_q + 8'd1;
  end

  assign illegal_cnt = cnt_q;
`else
  assign illegal_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench for control_unit: directed decode vectors, randomized decode
// against a behavioural model, illegal-event tracking, and clock independence.
module tb_control_unit;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       clk_run = 1'b1;
  logic [6:0] opcode = 7'b0010011;
  logic [2:0] funct3 = 3'b000;
  logic [6:0] funct7 = 7'b0000000;
  logic       reg_write, mem_read, mem_write, branch, jump;
  logic [1:0] alu_src, reg_write_src;
  logic [3:0] alu_op;
  logic       illegal_inst, illegal_sticky;
  logic [7:0] illegal_cnt;
  logic [13:0] obs;

  int n_checks = 0;
  int n_pass   = 0;

  control_unit dut (
    .clk            (clk),
    .rst            (rst),
    .opcode         (opcode),
    .funct3         (funct3),
    .funct7         (funct7),
    .reg_write      (reg_write),
    .mem_read       (mem_read),
    .mem_write      (mem_write),
    .branch         (branch),
    .jump           (jump),
    .alu_src        (alu_src),
    .alu_op         (alu_op),
    .reg_write_src  (reg_write_src),
    .illegal_inst   (illegal_inst),
    .illegal_sticky (illegal_sticky),
    .illegal_cnt    (illegal_cnt)
  );

  always #5 if (clk_run) clk = ~clk;

  // {illegal, rw, mr, mw, br, jmp, alu_src[1:0], alu_op[3:0], wb_src[1:0]}
  assign obs = {illegal_inst, reg_write, mem_read, mem_write, branch, jump,
                alu_src, alu_op, reg_write_src};

  // Behavioural reference built directly from the instruction-class table.
  function automatic logic [13:0] model(input logic [6:0] op, input logic [2:0] f3,
                                        input logic [6:0] f7);
    logic ill, rw, mr, mw, br, jmp;
    logic [1:0] as_, rws;
    int ao;
    ill = 0; rw = 0; mr = 0; mw = 0; br = 0; jmp = 0; as_ = 0; rws = 0; ao = 0;
    case (op)
      7'b0110011: begin
        if (f7 == 7'd0) begin rw = 1; ao = int'(f3); end
        else if (f7 == 7'd32 && (f3 == 3'd0 || f3 == 3'd5)) begin rw = 1; ao = int'(f3) + 8; end
        else ill = 1;
      end
      7'b0010011: begin
        rw = 1; as_ = 2'd1;
        ao = int'(f3) + ((f3 == 3'd5 && f7[5]) ? 8 : 0);
      end
      7'b0000011: begin rw = 1; mr = 1; as_ = 2'd1; rws = 2'd1; end
      7'b0100011: begin mw = 1; as_ = 2'd1; end
      7'b1100011: begin
        if (f3 == 3'd2 || f3 == 3'd3) ill = 1;
        else begin br = 1; ao = (f3 < 3'd2) ? 8 : (f3 < 3'd6) ? 2 : 3; end
      end
      7'b1101111: begin rw = 1; jmp = 1; rws = 2'd2; end
      7'b1100111: begin rw = 1; jmp = 1; as_ = 2'd1; rws = 2'd2; end
      7'b0110111: begin rw = 1; rws = 2'd3; end
      7'b0010111: begin rw = 1; as_ = 2'd2; end
      7'b0001111, 7'b1110011: ;
      default: ill = 1;
    endcase
    return {ill, rw, mr, mw, br, jmp, as_, 4'(ao), rws};
  endfunction

  localparam int N_DIR = 18;
  logic [6:0]  d_op  [N_DIR] = '{7'b0110011, 7'b0110011, 7'b0110011, 7'b0110011,
                                 7'b0010011, 7'b0010011, 7'b0000011, 7'b0100011,
                                 7'b1100011, 7'b1100011, 7'b1101111, 7'b1100111,
                                 7'b0110111, 7'b0010111, 7'b1111111, 7'b1100011,
                                 7'b0001111, 7'b0110011};
  logic [2:0]  d_f3  [N_DIR] = '{3'd0, 3'd0, 3'd5, 3'd7, 3'd0, 3'd3, 3'd2, 3'd2,
                                 3'd0, 3'd6, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd2,
                                 3'd0, 3'd0};
  logic [6:0]  d_f7  [N_DIR] = '{7'h00, 7'h20, 7'h20, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00,
                                 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00,
                                 7'h00, 7'h01};
  logic [13:0] d_exp [N_DIR] = '{14'b0_10000_00_0000_00, 14'b0_10000_00_1000_00,
                                 14'b0_10000_00_1101_00, 14'b0_10000_00_0111_00,
                                 14'b0_10000_01_0000_00, 14'b0_10000_01_0011_00,
                                 14'b0_11000_01_0000_01, 14'b0_00100_01_0000_00,
                                 14'b0_00010_00_1000_00, 14'b0_00010_00_0011_00,
                                 14'b0_10001_00_0000_10, 14'b0_10001_01_0000_10,
                                 14'b0_10000_00_0000_11, 14'b0_10000_10_0000_00,
                                 14'b1_00000_00_0000_00, 14'b1_00000_00_0000_00,
                                 14'b0_00000_00_0000_00, 14'b1_00000_00_0000_00};
  string       d_name[N_DIR] = '{"add", "sub", "sra", "and", "addi", "sltiu", "lw", "sw",
                                 "beq", "bltu", "jal", "jalr", "lui", "auipc", "op_7f",
                                 "branch_f3_010", "fence", "r_f7_01"};

  function automatic logic [7:0] exp_cnt(input int edges);
`ifdef CTRL_ILLEGAL_CNT_EN
    return (edges > 255) ? 8'd255 : 8'(edges);
`else
    return (edges > 0) ? 8'd0 : 8'd0;
`endif
  endfunction

  task automatic test_reset();
    #2;
    n_checks++;
    if (illegal_sticky !== 1'b0 || illegal_cnt !== 8'd0)
      $display("FAIL reset_state: sticky=%b cnt=%0d, required sticky=0 cnt=0", illegal_sticky, illegal_cnt);
    else n_pass++;
    n_checks++;
    if (obs !== 14'b0_10000_01_0000_00)
      $display("FAIL reset_decode_addi: got %b, required %b", obs, 14'b0_10000_01_0000_00);
    else n_pass++;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_directed();
    for (int i = 0; i < N_DIR; i++) begin
      opcode = d_op[i]; funct3 = d_f3[i]; funct7 = d_f7[i];
      #1;
      n_checks++;
      if (obs !== d_exp[i])
        $display("FAIL dir_%s: got %b, required %b", d_name[i], obs, d_exp[i]);
      else n_pass++;
    end
  endtask

  task automatic test_random();
    logic [6:0] legal_ops [11] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011,
                                   7'b1100011, 7'b1101111, 7'b1100111, 7'b0110111,
                                   7'b0010111, 7'b0001111, 7'b1110011};
    logic [13:0] exp;
    int bad = 0;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 9) < 8) opcode = legal_ops[$urandom_range(0, 10)];
      else opcode = 7'($urandom);
      funct3 = 3'($urandom);
      case ($urandom_range(0, 2))
        0: funct7 = 7'h00;
        1: funct7 = 7'h20;
        default: funct7 = 7'($urandom);
      endcase
      #1;
      exp = model(opcode, funct3, funct7);
      n_checks++;
      if (obs !== exp) begin
        if (bad < 10)
          $display("FAIL rand_decode op=%b f3=%b f7=%b: got %b, required %b",
                   opcode, funct3, funct7, obs, exp);
        bad++;
      end else n_pass++;
      n_checks++;
      if (exp[13] && (reg_write | mem_write | branch | jump) !== 1'b0)
        $display("FAIL rand_illegal_commit op=%b: rw=%b mw=%b br=%b jmp=%b, required all 0",
                 opcode, reg_write, mem_write, branch, jump);
      else n_pass++;
    end
  endtask

  task automatic test_sequential();
    @(negedge clk);
    rst = 1'b1; #1 rst = 1'b0;
    opcode = 7'b0010011; funct3 = 3'd0; funct7 = 7'h00;
    repeat (3) @(negedge clk);
    n_checks++;
    if (illegal_sticky !== 1'b0 || illegal_cnt !== 8'd0)
      $display("FAIL legal_no_track: sticky=%b cnt=%0d, required 0/0", illegal_sticky, illegal_cnt);
    else n_pass++;

    opcode = 7'b1111111;
    for (int e = 1; e <= 300; e++) begin
      @(negedge clk);
      if (e == 1 || e == 10 || e == 254 || e == 255 || e == 256 || e == 300) begin
        n_checks++;
        if (illegal_sticky !== 1'b1 || illegal_cnt !== exp_cnt(e))
          $display("FAIL illegal_track_%0d: sticky=%b cnt=%0d, required sticky=1 cnt=%0d",
                   e, illegal_sticky, illegal_cnt, exp_cnt(e));
        else n_pass++;
      end
    end

    rst = 1'b1; #1 rst = 1'b0;
    for (int e = 1; e <= 40; e++) @(negedge clk);
    n_checks++;
    if (illegal_cnt !== exp_cnt(40) || illegal_sticky !== 1'b1)
      $display("FAIL recount_40: sticky=%b cnt=%0d, required sticky=1 cnt=%0d",
               illegal_sticky, illegal_cnt, exp_cnt(40));
    else n_pass++;
    #1 rst = 1'b1;
    #1;
    n_checks++;
    if (illegal_sticky !== 1'b0 || illegal_cnt !== 8'd0)
      $display("FAIL async_clear: sticky=%b cnt=%0d, required 0/0", illegal_sticky, illegal_cnt);
    else n_pass++;
    opcode = 7'b0110111;
    #1 rst = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (illegal_sticky !== 1'b0 || illegal_cnt !== 8'd0)
      $display("FAIL post_reset_hold: sticky=%b cnt=%0d, required 0/0", illegal_sticky, illegal_cnt);
    else n_pass++;
  endtask

  task automatic test_clock_independence();
    @(negedge clk);
    clk_run = 1'b0;
    clk = 1'bx; rst = 1'bx;
    for (int i = 0; i < 14; i++) begin
      opcode = d_op[i]; funct3 = d_f3[i]; funct7 = d_f7[i];
      #3;
      n_checks++;
      if (obs !== d_exp[i])
        $display("FAIL clkx_%s: got %b, required %b", d_name[i], obs, d_exp[i]);
      else n_pass++;
    end
    clk = 1'b0; rst = 1'b1;
    #1 rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_sequential();
    test_clock_independence();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
